inert_seq: RTL and testbench
============================

Name: inert_seq

Overview:
- Command sequencer sitting directly upstream of the 16-bit SPI master. It drives wrt/cmd to the master and consumes done/rd_data.
- After a power-up delay it writes four configuration words to the inertial sensor.
- It then waits for the sensor's data-ready interrupt (INT) and performs four register reads.
- It assembles the read bytes into 16-bit pitch-rate and Z-accel words and pulses vld when a new sample is complete.

Parameters:
PWRUP_BITS  16  width of power-up delay counter; delay = 2^PWRUP_BITS clocks (set to 4 in simulation)

Ports:
clk      input   1   system clock
rst_n    input   1   reset, synchronous, active-low
INT      input   1   sensor data-ready interrupt, asynchronous
done     input   1   from SPI master; high at reset, cleared the cycle after wrt, set at transaction end, held until next wrt
rd_data  input   16  from SPI master; byte of interest is [7:0]
wrt      output  1   one-cycle pulse to start an SPI transaction
cmd      output  16  SPI command word, valid in the cycle wrt is high
ptch_rt  output  16  pitch rate {PTCH_H,PTCH_L}
AZ       output  16  Z acceleration {AZ_H,AZ_L}
vld      output  1   one-cycle pulse: new ptch_rt/AZ pair available

Behaviour:
- Reset: one clock, synchronous, active-low.
  - All flops clear on a clk edge with rst_n low.
  - Outputs: wrt=0, cmd=16'h0000, ptch_rt=16'h0000, AZ=16'h0000, vld=0.
  - State=PWRUP, index=0, INT synchronizer=0, pending=0.
- Reset mid-transaction:
  - Abandon the sequence and return to PWRUP; no partial sample is published.
  - Restarts the full delay and the full init sequence.
- INT handling:
  - Double-flop synchronizer plus a third flop for rising-edge detect.
  - The edge sets a pending flag.
  - Pending clears when the read sequence starts.
  - An edge arriving during reads re-sets pending, so exactly one extra sequence follows.
- States: PWRUP, INIT_ISSUE, INIT_WAIT, IDLE, RD_ISSUE, RD_WAIT; 2-bit index selects the command.
- PWRUP:
  - Counter increments every clock.
  - When all ones, go to INIT_ISSUE with index=0.
- INIT_ISSUE:
  - wrt=1 for exactly one cycle, cmd=INIT_CMD[index].
  - Go to INIT_WAIT.
- INIT_WAIT:
  - done is low from the first cycle after wrt.
  - On done=1: if index=3, go to IDLE with index=0; else index+1 and go to INIT_ISSUE.
- IDLE:
  - If pending, go to RD_ISSUE with index=0 and clear pending.
- RD_ISSUE:
  - wrt=1 for one cycle, cmd=RD_CMD[index].
  - Go to RD_WAIT.
- RD_WAIT, on done=1:
  - Capture rd_data[7:0] into shadow byte[index].
  - If index=3, go to IDLE and set the publish strobe; else index+1 and go to RD_ISSUE.
- Publish:
  - The cycle after the AZ_H capture, ptch_rt and AZ load atomically from the shadows and vld=1 for that one cycle.
  - Outputs hold between publishes.
- cmd is only meaningful while wrt=1.
  - cmd holds its last value otherwise; it is 16'h0000 until the first issue.
- Minimum spacing: wrt is never asserted on consecutive cycles.
  - At least one WAIT cycle separates issues.
- done=1 at reset does not satisfy any WAIT state, because WAIT is only entered after a wrt.
- Init order: 0x0D02, 0x1053, 0x1150, 0x1460.
- Read order: 0xA200 (PTCH_L), 0xA300 (PTCH_H), 0xAC00 (AZ_L), 0xAD00 (AZ_H).
- Width rules:
  - Bytes concatenate high:low with no sign manipulation.
  - The power-up counter saturates transition-only; it is not used after PWRUP.

Decomposition:
- Package inert_pkg holds:
  - state enum typedef;
  - localparams INIT_CMD[0:3] and RD_CMD[0:3];
  - shadow-byte index names (PTCH_L=0, PTCH_H=1, AZ_L=2, AZ_H=3).
- One natural sub-module: int_sync_edge.
  - Contents: 3-flop synchronizer and rising-edge detector with synchronous active-low reset.
  - Outputs: INT_rise.
- Everything else stays in inert_seq.

Test Plan:
- Bench setup: PWRUP_BITS=4 throughout, SPI master replaced by a responder that drops done the cycle after wrt and raises it N=20 cycles later.
- Reset then release -> wrt stays 0 for 15 cycles; first wrt has cmd=16'h0D02, then 0x1053, 0x1150, 0x1460 in order, one wrt per done rise; no further wrt without INT.
- After init, pulse INT with responder returning rd_data low bytes 0x34, 0x12, 0x78, 0x56 -> four wrts with cmds 0xA200, 0xA300, 0xAC00, 0xAD00; exactly one vld pulse; ptch_rt=16'h1234, AZ=16'h5678 in the vld cycle and held after.
- Second INT edge during the RD_WAIT of index 1 -> current sample completes with vld, then exactly one more 4-read sequence; INT held high continuously gives no further sequences.
- Deassert rst_n during the third read (index 2) -> next clk: wrt=0, vld=0, outputs 0; no vld ever for the aborted sample; PWRUP delay and init sequence repeat from 0x0D02.
- INT pulse during PWRUP/init -> reads begin only after the 0x1460 write completes, one sequence; wrt never high on two consecutive cycles (assertion throughout).

Source files
------------

// File: rtl/inert_pkg.sv
// Shared types and command tables for the inertial-sensor command sequencer.
package inert_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        RD_ISSUE,
        RD_WAIT
    } state_t;

    localparam logic [15:0] INIT_CMD [0:3] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    localparam logic [15:0] RD_CMD   [0:3] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

    // Shadow-byte slots, in the order the read commands fetch them
    localparam logic [1:0] PTCH_L = 2'd0;
    localparam logic [1:0] PTCH_H = 2'd1;
    localparam logic [1:0] AZ_L   = 2'd2;
    localparam logic [1:0] AZ_H   = 2'd3;

endpackage

// File: rtl/inert_seq_int_sync_edge.sv
// Synchronizes the asynchronous sensor interrupt and flags its rising edge.
module int_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic INT,
    output logic INT_rise
);

    logic int_ff1, int_ff2, int_ff3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
            int_ff3 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
            int_ff3 <= int_ff2;
        end
    end

    assign INT_rise = int_ff2 & ~int_ff3;

endmodule

// File: rtl/inert_seq.sv
// Sensor command sequencer: power-up delay, four config writes, then four
// register reads per data-ready interrupt, publishing pitch rate and Z accel.
module inert_seq
    import inert_pkg::*;
#(
    parameter int PWRUP_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
);

    state_t                state;
    logic [1:0]            idx;
    logic [1:0]            idx_nxt;
    logic [PWRUP_BITS-1:0] pwr_cnt;
    logic                  pending;
    logic                  publish;
    logic [7:0]            shadow [0:3];
    logic                  int_rise;
    logic                  unused_rd_hi;

    assign idx_nxt      = idx + 2'd1;
    assign unused_rd_hi = ^rd_data[15:8];

    int_sync_edge u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .INT      (INT),
        .INT_rise (int_rise)
    );

    // wrt/cmd are set on the transition into an ISSUE state, so wrt is high
    // exactly while in ISSUE and WAIT never sees the previous transaction's done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= PWRUP;
            idx     <= 2'd0;
            pwr_cnt <= '0;
            pending <= 1'b0;
            publish <= 1'b0;
            wrt     <= 1'b0;
            cmd     <= 16'h0000;
            ptch_rt <= 16'h0000;
            AZ      <= 16'h0000;
            vld     <= 1'b0;
            shadow  <= '{default: 8'h00};
        end else begin
            wrt     <= 1'b0;
            vld     <= 1'b0;
            publish <= 1'b0;
            if (int_rise)
                pending <= 1'b1;

            if (publish) begin
                ptch_rt <= {shadow[PTCH_H], shadow[PTCH_L]};
                AZ      <= {shadow[AZ_H], shadow[AZ_L]};
                vld     <= 1'b1;
            end

            case (state)
                PWRUP: begin
                    if (&pwr_cnt) begin
                        state <= INIT_ISSUE;
                        idx   <= 2'd0;
                        wrt   <= 1'b1;
                        cmd   <= INIT_CMD[0];
                    end else begin
                        pwr_cnt <= pwr_cnt + 1'b1;
                    end
                end
                INIT_ISSUE: state <= INIT_WAIT;
                INIT_WAIT: begin
                    if (done) begin
                        if (idx == 2'd3) begin
                            state <= IDLE;
                            idx   <= 2'd0;
                        end else begin
                            state <= INIT_ISSUE;
                            idx   <= idx_nxt;
                            wrt   <= 1'b1;
                            cmd   <= INIT_CMD[idx_nxt];
                        end
                    end
                end
                IDLE: begin
                    if (pending) begin
                        state <= RD_ISSUE;
                        idx   <= 2'd0;
                        wrt   <= 1'b1;
                        cmd   <= RD_CMD[0];
                        // An edge landing in this same cycle must survive
                        if (!int_rise)
                            pending <= 1'b0;
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    if (done) begin
                        shadow[idx] <= rd_data[7:0];
                        if (idx == 2'd3) begin
                            state   <= IDLE;
                            idx     <= 2'd0;
                            publish <= 1'b1;
                        end else begin
                            state <= RD_ISSUE;
                            idx   <= idx_nxt;
                            wrt   <= 1'b1;
                            cmd   <= RD_CMD[idx_nxt];
                        end
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_inert_seq.sv
// Bench for inert_seq: SPI responder model plus transaction-level expected queues.
module tb_inert_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  rsp [4];
    logic [15:0] wrt_q[$];
    logic [31:0] vld_q[$];
    logic [15:0] exp_cmd_q[$];
    logic [31:0] exp_vld_q[$];
    logic        prev_wrt = 1'b0;
    int          busy_cnt;
    logic [15:0] cur_cmd;

    always #5 clk = ~clk;

    inert_seq #(.PWRUP_BITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rsp_byte(input logic [15:0] c);
        case (c[15:8])
            8'hA2:   return rsp[0];
            8'hA3:   return rsp[1];
            8'hAC:   return rsp[2];
            8'hAD:   return rsp[3];
            default: return 8'($urandom);
        endcase
    endfunction

    // SPI master stand-in: done drops after wrt, rises 20 cycles later with data
    always @(posedge clk) begin
        if (!rst_n) begin
            done     <= 1'b1;
            busy_cnt <= 0;
        end else if (wrt) begin
            done     <= 1'b0;
            busy_cnt <= 20;
            cur_cmd  <= cmd;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                done    <= 1'b1;
                rd_data <= {8'($urandom), rsp_byte(cur_cmd)};
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (wrt) begin
                check_eq("wrt_spacing", {31'b0, prev_wrt}, 32'd0);
                wrt_q.push_back(cmd);
            end
            if (vld)
                vld_q.push_back({ptch_rt, AZ});
        end
        prev_wrt = wrt;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_wrt", {31'b0, wrt}, 32'd0);
        check_eq("rst_vld", {31'b0, vld}, 32'd0);
        check_eq("rst_cmd", {16'b0, cmd}, 32'h0);
        check_eq("rst_ptch", {16'b0, ptch_rt}, 32'h0);
        check_eq("rst_az", {16'b0, AZ}, 32'h0);
        wait_cycles(2);
        wrt_q.delete();
        vld_q.delete();
        exp_cmd_q.delete();
        exp_vld_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_first_wrt();
        int n = 0;
        while (!wrt && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("pwrup_delay", {31'b0, (n >= 16 && n <= 17)}, 32'd1);
    endtask

    task automatic wait_wrt(input int n, input int budget);
        int k = 0;
        while (wrt_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("wrt_count_reached", {31'b0, (wrt_q.size() >= n)}, 32'd1);
    endtask

    task automatic wait_vld(input int n, input int budget);
        int k = 0;
        while (vld_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("vld_count_reached", {31'b0, (vld_q.size() >= n)}, 32'd1);
    endtask

    task automatic pulse_int();
        @(negedge clk);
        INT = 1'b1;
        wait_cycles(3);
        INT = 1'b0;
    endtask

    task automatic randomize_rsp();
        for (int i = 0; i < 4; i++)
            rsp[i] = 8'($urandom);
    endtask

    task automatic expect_init();
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1053);
        exp_cmd_q.push_back(16'h1150);
        exp_cmd_q.push_back(16'h1460);
    endtask

    task automatic expect_read();
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        exp_cmd_q.push_back(16'hAD00);
        exp_vld_q.push_back({rsp[1], rsp[0], rsp[3], rsp[2]});
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, "_ncmd"}, wrt_q.size(), exp_cmd_q.size());
        for (int i = 0; i < wrt_q.size() && i < exp_cmd_q.size(); i++)
            check_eq({tag, "_cmd"}, {16'b0, wrt_q[i]}, {16'b0, exp_cmd_q[i]});
        check_eq({tag, "_nvld"}, vld_q.size(), exp_vld_q.size());
        for (int i = 0; i < vld_q.size() && i < exp_vld_q.size(); i++)
            check_eq({tag, "_sample"}, vld_q[i], exp_vld_q[i]);
    endtask

    initial begin
        int base;
        int nv;
        rst_n   = 1'b0;
        INT     = 1'b0;
        rd_data = 16'h0000;
        randomize_rsp();

        // Power-up and init sequence
        apply_reset();
        expect_init();
        wait_first_wrt();
        wait_wrt(4, 300);
        wait_cycles(150);
        compare_all("init");

        // Fixed-pattern read
        rsp[0] = 8'h34; rsp[1] = 8'h12; rsp[2] = 8'h78; rsp[3] = 8'h56;
        expect_read();
        pulse_int();
        wait_vld(1, 400);
        wait_cycles(50);
        check_eq("hold_ptch", {16'b0, ptch_rt}, 32'h1234);
        check_eq("hold_az", {16'b0, AZ}, 32'h5678);
        compare_all("read1");

        // Second edge during the index-1 read, then INT held high
        randomize_rsp();
        expect_read();
        base = wrt_q.size();
        nv   = vld_q.size();
        pulse_int();
        wait_wrt(base + 2, 200);
        wait_cycles(5);
        INT = 1'b1;
        wait_vld(nv + 1, 400);
        randomize_rsp();
        expect_read();
        wait_vld(nv + 2, 400);
        wait_cycles(300);
        INT = 1'b0;
        compare_all("b2b");
        check_eq("b2b_hold", {ptch_rt, AZ}, exp_vld_q[exp_vld_q.size()-1]);

        // Randomized read sequences with random gaps
        for (int it = 0; it < 3; it++) begin
            randomize_rsp();
            expect_read();
            nv = vld_q.size();
            pulse_int();
            wait_vld(nv + 1, 400);
            wait_cycles($urandom_range(10, 60));
        end
        compare_all("rand");

        // Reset in the middle of the third read
        randomize_rsp();
        base = wrt_q.size();
        pulse_int();
        wait_wrt(base + 3, 200);
        wait_cycles(5);
        apply_reset();
        expect_init();
        wait_first_wrt();
        wait_wrt(4, 300);
        wait_cycles(150);
        compare_all("abort");
        check_eq("abort_ptch", {16'b0, ptch_rt}, 32'h0);

        // Interrupts during power-up and init yield exactly one read sequence
        apply_reset();
        randomize_rsp();
        expect_init();
        expect_read();
        wait_cycles(5);
        pulse_int();
        wait_wrt(2, 300);
        pulse_int();
        wait_vld(1, 800);
        wait_cycles(200);
        compare_all("early_int");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
